// File: rtl/sb_deserializer_fifo.sv
// Sideband deserializer: packs a LANES-wide serial stream (LSB first) into WIDTH-bit
// packets and queues them in a DEPTH-entry ready/valid FIFO. All state moves on the falling edge.
module sb_deserializer_fifo #(
  parameter  int WIDTH = 128,
  parameter  int LANES = 1,
  parameter  int DEPTH = 2,
  localparam int BEATS = WIDTH / LANES,
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int LW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_abort,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LW-1:0]    level,
  output logic             busy,
  output logic             overflow,
  input  logic             clear_overflow
);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;

  logic push;
  logic pop;
  logic full;
  logic push_ok;
  logic drop;

  // Beat assembly: abort wins over a valid beat, and a completed packet is offered as push.
  always_comb begin
    asm_d = asm_q;
    cnt_d = cnt_q;
    push  = 1'b0;
    if (in_abort) begin
      cnt_d = '0;
    end else if (in_valid) begin
      asm_d[int'(cnt_q) * LANES +: LANES] = in_data;
      if (cnt_q == CW'(BEATS - 1)) begin
        cnt_d = '0;
        push  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // FIFO bookkeeping; a push at full is still taken when the head leaves on the same edge.
  always_comb begin
    pop     = out_valid_q & out_ready;
    full    = (level_q == LW'(DEPTH));
    push_ok = push & (~full | pop);
    drop    = push & full & ~pop;

    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = asm_d;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    // Head register follows the next read pointer, so it only moves on a pop or a push into empty.
    out_data_d  = mem_d[rd_ptr_d];
    out_valid_d = (level_d != '0);
    busy_d      = (cnt_d != '0);
  end

  // State registers, cleared asynchronously.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      asm_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign level     = level_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sb_deserializer_fifo.sv
// Bench for sb_deserializer_fifo: a 4-lane/32-bit instance checked every cycle against a
// queue-based model, plus a 1-lane/128-bit instance exercised with directed packets.
module tb_sb_deserializer_fifo;

  logic clk;
  logic rst;

  logic [3:0]   a_data;
  logic         a_valid, a_abort, a_ready, a_clr;
  logic [31:0]  a_out_data;
  logic         a_out_valid, a_busy, a_ovf;
  logic [1:0]   a_level;

  logic [0:0]   w_data;
  logic         w_valid, w_abort, w_ready, w_clr;
  logic [127:0] w_out_data;
  logic         w_out_valid, w_busy, w_ovf;
  logic [1:0]   w_level;

  int n_tests;
  int n_fail;
  bit chk_en;

  sb_deserializer_fifo #(.WIDTH(32), .LANES(4), .DEPTH(2)) u_dut (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_abort(a_abort),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_ready), .level(a_level),
    .busy(a_busy), .overflow(a_ovf), .clear_overflow(a_clr)
  );

  sb_deserializer_fifo #(.WIDTH(128), .LANES(1), .DEPTH(2)) u_wide (
    .clk(clk), .rst(rst), .in_data(w_data), .in_valid(w_valid), .in_abort(w_abort),
    .out_data(w_out_data), .out_valid(w_out_valid), .out_ready(w_ready), .level(w_level),
    .busy(w_busy), .overflow(w_ovf), .clear_overflow(w_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model of the 4-lane instance: list of beats in flight and a queue of packets.
  logic [31:0] mq[$];
  logic [3:0]  mbeats[$];
  bit          movf;
  bit          m_pop, m_push, m_drop;
  int          m_sz;
  logic [31:0] m_pkt;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mbeats.delete();
      movf = 1'b0;
    end else begin
      m_sz   = mq.size();
      m_pop  = (m_sz > 0) && a_ready;
      m_push = 1'b0;
      m_pkt  = 32'd0;
      if (a_abort) begin
        mbeats.delete();
      end else if (a_valid) begin
        mbeats.push_back(a_data);
        if (mbeats.size() == 8) begin
          for (int i = 0; i < 8; i++) m_pkt = m_pkt + (32'(mbeats[i]) << (4 * i));
          mbeats.delete();
          m_push = 1'b1;
        end
      end
      if (m_pop) void'(mq.pop_front());
      m_drop = m_push && (m_sz == 2) && !m_pop;
      if (m_push && !m_drop) mq.push_back(m_pkt);
      movf = m_drop ? 1'b1 : (a_clr ? 1'b0 : movf);
    end
  end

  // Per-cycle comparison of the 4-lane instance against the model.
  always @(posedge clk) begin
    if (chk_en && !rst) begin
      chk("model out_valid", a_out_valid, mq.size() != 0);
      chk("model level", a_level, mq.size());
      chk("model busy", a_busy, mbeats.size() != 0);
      chk("model overflow", a_ovf, movf);
      if (mq.size() != 0) chk("model out_data", a_out_data, mq[0]);
    end
  end

  task automatic a_edge(input logic v, input logic ab, input logic [3:0] d, input logic r, input logic c);
    a_valid = v; a_abort = ab; a_data = d; a_ready = r; a_clr = c;
    w_valid = 1'b0; w_abort = 1'b0; w_data = 1'b0; w_ready = 1'b0; w_clr = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic a_pkt(input logic [31:0] p, input logic r_last, input logic c_last);
    for (int i = 0; i < 8; i++) begin
      a_edge(1'b1, 1'b0, p[4*i +: 4], (i == 7) ? r_last : 1'b0, (i == 7) ? c_last : 1'b0);
    end
  endtask

  task automatic w_edge(input logic v, input logic b, input logic r);
    w_valid = v; w_abort = 1'b0; w_data = b; w_ready = r; w_clr = 1'b0;
    a_valid = 1'b0; a_abort = 1'b0; a_data = 4'h0; a_ready = 1'b0; a_clr = 1'b0;
    @(negedge clk);
    #1;
  endtask

  logic [127:0] pat;
  logic [127:0] pat2;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    chk_en  = 1'b0;
    pat  = 128'hDEADBEEF_00112233_44556677_8899AABB;
    pat2 = ~pat;
    rst = 1'b1;
    a_valid = 1'b0; a_abort = 1'b0; a_data = 4'h0; a_ready = 1'b0; a_clr = 1'b0;
    w_valid = 1'b0; w_abort = 1'b0; w_data = 1'b0; w_ready = 1'b0; w_clr = 1'b0;
    #2;
    chk("reset out_valid", a_out_valid, 1'b0);
    chk("reset level", a_level, 2'd0);
    chk("reset busy", a_busy, 1'b0);
    chk("reset out_data", a_out_data, 32'd0);
    chk("reset overflow", a_ovf, 1'b0);
    chk("reset wide out_data", w_out_data, 128'd0);
    chk("reset wide out_valid", w_out_valid, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Abort mid-packet, then a clean packet 1..8.
    for (int i = 0; i < 5; i++) a_edge(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
    chk("partial busy", a_busy, 1'b1);
    a_edge(1'b1, 1'b1, 4'hA, 1'b0, 1'b0);
    chk("abort busy", a_busy, 1'b0);
    chk("abort level", a_level, 2'd0);
    for (int i = 1; i <= 8; i++) begin
      a_edge(1'b1, 1'b0, 4'(i), 1'b0, 1'b0);
      if (i == 7) chk("beat7 out_valid", a_out_valid, 1'b0);
    end
    chk("abort pkt out_valid", a_out_valid, 1'b1);
    chk("abort pkt out_data", a_out_data, 32'h87654321);
    chk("abort pkt level", a_level, 2'd1);
    chk("abort pkt busy", a_busy, 1'b0);
    a_edge(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("drain level", a_level, 2'd0);

    // Abort on what would have been the last beat pushes nothing.
    for (int i = 0; i < 7; i++) a_edge(1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
    a_edge(1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
    chk("last-beat abort level", a_level, 2'd0);

    // Overflow: third packet dropped, then pop and clear; drop+clear on one edge keeps it set.
    a_pkt(32'h1234_5678, 1'b0, 1'b0);
    a_pkt(32'h9ABC_DEF0, 1'b0, 1'b0);
    a_pkt(32'h0F1E_2D3C, 1'b0, 1'b0);
    chk("ovf level", a_level, 2'd2);
    chk("ovf flag", a_ovf, 1'b1);
    chk("ovf head", a_out_data, 32'h1234_5678);
    a_edge(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("ovf pop head", a_out_data, 32'h9ABC_DEF0);
    chk("ovf pop level", a_level, 2'd1);
    a_edge(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("ovf cleared", a_ovf, 1'b0);
    a_pkt(32'hCAFE_F00D, 1'b0, 1'b0);
    a_pkt(32'h5555_AAAA, 1'b0, 1'b1);
    chk("drop beats clear", a_ovf, 1'b1);
    a_edge(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    chk("second pop head", a_out_data, 32'hCAFE_F00D);
    chk("second clear", a_ovf, 1'b0);
    a_edge(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("ovf drained", a_level, 2'd0);

    // Push at full with a simultaneous pop is accepted.
    a_pkt(32'h1111_2222, 1'b0, 1'b0);
    a_pkt(32'h3333_4444, 1'b0, 1'b0);
    a_pkt(32'h5555_6666, 1'b1, 1'b0);
    chk("simul level", a_level, 2'd2);
    chk("simul ovf", a_ovf, 1'b0);
    chk("simul head", a_out_data, 32'h3333_4444);
    a_edge(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("simul pop C", a_out_data, 32'h5555_6666);
    a_edge(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("simul drained", a_out_valid, 1'b0);

    // Wide instance: 128-bit pattern, LSB first.
    for (int i = 0; i < 127; i++) w_edge(1'b1, pat[i], 1'b0);
    chk("wide beat127 valid", w_out_valid, 1'b0);
    chk("wide beat127 busy", w_busy, 1'b1);
    w_edge(1'b1, pat[127], 1'b0);
    chk("wide valid", w_out_valid, 1'b1);
    chk("wide data", w_out_data, pat);
    chk("wide level", w_level, 2'd1);
    chk("wide busy", w_busy, 1'b0);
    w_edge(1'b0, 1'b0, 1'b1);
    chk("wide drained", w_level, 2'd0);

    // Same packet with a 10-edge gap after beat 50.
    for (int i = 0; i < 50; i++) w_edge(1'b1, pat[i], 1'b0);
    for (int g = 0; g < 10; g++) begin
      w_edge(1'b0, 1'b0, 1'b0);
      chk("gap busy", w_busy, 1'b1);
    end
    for (int i = 50; i < 127; i++) w_edge(1'b1, pat[i], 1'b0);
    chk("gap beat127 valid", w_out_valid, 1'b0);
    w_edge(1'b1, pat[127], 1'b0);
    chk("gap valid", w_out_valid, 1'b1);
    chk("gap data", w_out_data, pat);

    // Reset with a queued packet and 40 beats of a partial one.
    for (int i = 0; i < 40; i++) w_edge(1'b1, pat2[i], 1'b0);
    chk("pre-reset busy", w_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid reset valid", w_out_valid, 1'b0);
    chk("mid reset level", w_level, 2'd0);
    chk("mid reset busy", w_busy, 1'b0);
    chk("mid reset data", w_out_data, 128'd0);
    rst = 1'b0;
    for (int i = 0; i < 128; i++) w_edge(1'b1, pat2[i], 1'b0);
    chk("post-reset data", w_out_data, pat2);
    chk("post-reset level", w_level, 2'd1);
    w_edge(1'b0, 1'b0, 1'b1);

    // Random traffic on the 4-lane instance, with sweeping consumer rate and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      a_edge($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 4'($urandom),
             $urandom_range(0, 3) < ((n / 500) % 4), $urandom_range(0, 29) == 0);
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        #1;
        chk("random reset level", a_level, 2'd0);
        rst = 1'b0;
      end
    end
    for (int n = 0; n < 4; n++) a_edge(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
    chk("final drained", a_out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
